// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus controller: FSM states, request record, op codes
// and the address window check used when MEM_BUS_CTRL_RANGE_CHECK_EN is defined.
package mem_bus_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic        op;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  // 17-bit compare so a window ending at the top of the address space cannot wrap
  function automatic logic addr_in_range(input logic [15:0] addr, input logic [15:0] base,
                                         input int num);
    logic [16:0] a_v;
    logic [16:0] lo_v;
    logic [16:0] hi_v;
    a_v  = {1'b0, addr};
    lo_v = {1'b0, base};
    hi_v = lo_v + 17'(num);
    return (a_v >= lo_v) && (a_v < hi_v);
  endfunction

endpackage

// File: rtl/mem_bus_req_fifo.sv
// Synchronous request FIFO: wrap-around read/write pointers plus an occupancy count.
// Pushes when full and pops when empty are ignored.
module mem_bus_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_MAX);
  assign level_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // storage array, no reset needed since reads are gated by the count
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// In-order request/response bridge onto a single-cycle-issue memory bus.
// Define MEM_BUS_CTRL_RANGE_CHECK_EN to reject addresses outside the BASE_ADDR window.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h10,
  parameter int          NUM_WORDS  = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_op,
  input  logic [15:0]                   req_addr,
  input  logic [15:0]                   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_op,
  output logic [15:0]                   rsp_rdata,
  output logic                          rsp_err,
  output logic                          bus_valid,
  output logic                          bus_op,
  output logic [15:0]                   bus_addr,
  output logic [15:0]                   bus_wr_data,
  input  logic [15:0]                   bus_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  req_t   push_req_s;
  req_t   head_s;
  logic   fifo_empty_s;
  logic   fifo_full_s;
  logic   pop_s;
  logic   range_ok_s;
  state_e state_q;
  logic   rsp_valid_q, rsp_op_q, rsp_err_q;
  logic   [15:0] rsp_rdata_q;
  logic   bus_valid_q, bus_op_q;
  logic   [15:0] bus_addr_q, bus_wr_data_q;

  assign push_req_s = {req_op, req_addr, req_wdata};
  // ready is masked by reset so nothing is accepted while the FIFO is being cleared
  assign req_ready  = !fifo_full_s && !reset;
  assign pop_s      = (state_q == IDLE) && !fifo_empty_s;

`ifdef MEM_BUS_CTRL_RANGE_CHECK_EN
  assign range_ok_s = addr_in_range(head_s.addr, BASE_ADDR, NUM_WORDS);
`else
  assign range_ok_s = 1'b1;
`endif

  mem_bus_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(req_t))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_valid && req_ready),
    .push_data_i (push_req_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .level_o     (fifo_level)
  );

  // request sequencer with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rsp_valid_q   <= 1'b0;
      rsp_op_q      <= 1'b0;
      rsp_rdata_q   <= 16'h0;
      rsp_err_q     <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_op_q      <= 1'b0;
      bus_addr_q    <= 16'h0;
      bus_wr_data_q <= 16'h0;
    end else begin
      bus_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty_s) begin
            if (range_ok_s) begin
              bus_valid_q   <= 1'b1;
              bus_op_q      <= head_s.op;
              bus_addr_q    <= head_s.addr;
              bus_wr_data_q <= head_s.wdata;
              state_q       <= ISSUE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_op_q    <= head_s.op;
              rsp_rdata_q <= 16'h0;
              rsp_err_q   <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (bus_op_q == OP_WRITE) begin
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= OP_WRITE;
            rsp_rdata_q <= 16'h0;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
          end else begin
            state_q <= WAIT_RD;
          end
        end
        // memory returns read data one cycle after the bus strobe
        WAIT_RD: begin
          rsp_valid_q <= 1'b1;
          rsp_op_q    <= OP_READ;
          rsp_rdata_q <= bus_rd_data;
          rsp_err_q   <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign bus_valid   = bus_valid_q;
  assign bus_op      = bus_op_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a one-cycle-latency memory model on the bus.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_op;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_op, rsp_err;
  logic [15:0] rsp_rdata;
  logic        bus_valid, bus_op;
  logic [15:0] bus_addr, bus_wr_data, bus_rd_data;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  int bus_cnt = 0;

  bit   [15:0] mem [256];
  logic [15:0] rd_q;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.FIFO_DEPTH(4), .BASE_ADDR(16'h10), .NUM_WORDS(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .fifo_level(fifo_level)
  );

  // memory: writes land on the strobe edge, read data appears the cycle after
  always @(posedge clk) begin
    if (bus_valid) begin
      if (bus_op) mem[bus_addr[7:0]] <= bus_wr_data;
      rd_q    <= mem[bus_addr[7:0]];
      bus_cnt <= bus_cnt + 1;
    end
  end
  assign bus_rd_data = rd_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic op, input logic [15:0] addr, input logic [15:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    step();
    req_valid = 1'b0;
  endtask

  // lat counts cycles after the handshake cycle; 50 means no response came
  task automatic wait_rsp(output int lat, output logic op, output logic [15:0] rd,
                          output logic err);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      step();
      lat++;
    end
    op = rsp_op; rd = rsp_rdata; err = rsp_err;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    rsp_ready = 1'b0;
    repeat (3) step();
    total++;
    if ({rsp_valid, rsp_op, rsp_rdata, rsp_err, bus_valid, bus_op, bus_addr, bus_wr_data,
         fifo_level} !== 56'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rsp_v=%b rd=%h bus_v=%b addr=%h lvl=%0d required all 0",
               rsp_valid, rsp_rdata, bus_valid, bus_addr, fifo_level);
    end
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_req_ready: got %b required 0", req_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    int lat; logic op; logic [15:0] rd; logic err; int b0;
    b0 = bus_cnt;
    send_req(1'b1, 16'h12, 16'hA5A5);
    wait_rsp(lat, op, rd, err);
    total++;
    if (lat !== 3 || op !== 1'b1 || err !== 1'b0 || rd !== 16'h0) begin
      bad++;
      $display("FAIL write_rsp: got lat=%0d op=%b err=%b rd=%h required lat=3 op=1 err=0 rd=0000",
               lat, op, err, rd);
    end
    ack_rsp();
    total++;
    if (bus_cnt - b0 !== 1) begin
      bad++;
      $display("FAIL write_bus_strobes: got %0d required 1", bus_cnt - b0);
    end
    send_req(1'b0, 16'h12, 16'h0);
    wait_rsp(lat, op, rd, err);
    total++;
    if (lat !== 4 || op !== 1'b0 || err !== 1'b0 || rd !== 16'hA5A5) begin
      bad++;
      $display("FAIL read_rsp: got lat=%0d op=%b err=%b rd=%h required lat=4 op=0 err=0 rd=a5a5",
               lat, op, err, rd);
    end
    ack_rsp();
  endtask

  task automatic test_ffff_and_unwritten();
    int lat; logic op; logic [15:0] rd; logic err;
    send_req(1'b1, 16'h19, 16'hFFFF);
    wait_rsp(lat, op, rd, err);
    ack_rsp();
    send_req(1'b0, 16'h19, 16'h0);
    wait_rsp(lat, op, rd, err);
    total++;
    if (rd !== 16'hFFFF || err !== 1'b0) begin
      bad++;
      $display("FAIL read_19: got rd=%h err=%b required ffff/0", rd, err);
    end
    ack_rsp();
    send_req(1'b0, 16'h10, 16'h0);
    wait_rsp(lat, op, rd, err);
    total++;
    if (rd !== 16'h0000 || lat !== 4) begin
      bad++;
      $display("FAIL read_10: got rd=%h lat=%0d required 0000 lat=4", rd, lat);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    int lat; logic op; logic [15:0] rd; logic err;
    logic [15:0] addrs [5];
    logic [15:0] exp   [5];
    addrs = '{16'h12, 16'h13, 16'h14, 16'h13, 16'h12};
    exp   = '{16'hA5A5, 16'h1111, 16'h2222, 16'h1111, 16'hA5A5};
    send_req(1'b1, 16'h13, 16'h1111); wait_rsp(lat, op, rd, err); ack_rsp();
    send_req(1'b1, 16'h14, 16'h2222); wait_rsp(lat, op, rd, err); ack_rsp();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_op = 1'b0; req_addr = addrs[i];
      total++;
      if (req_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready_%0d: got %b required 1", i, req_ready);
      end
      step();
    end
    req_addr = 16'h10;
    total++;
    if (req_ready !== 1'b0 || fifo_level !== 3'd4) begin
      bad++;
      $display("FAIL b2b_full: got ready=%b level=%0d required ready=0 level=4",
               req_ready, fifo_level);
    end
    req_valid = 1'b0;
    repeat (5) step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5A5 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_hold: got v=%b rd=%h ready=%b required v=1 rd=a5a5 ready=0",
               rsp_valid, rsp_rdata, req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rsp(lat, op, rd, err);
      total++;
      if (rd !== exp[i] || lat >= 50) begin
        bad++;
        $display("FAIL b2b_rsp_%0d: got rd=%h required %h", i, rd, exp[i]);
      end
      ack_rsp();
    end
    total++;
    if (fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL b2b_drained: got level=%0d required 0", fifo_level);
    end
  endtask

  task automatic test_throughput();
    int t0, t1;
    logic [15:0] d0, d1;
    logic [15:0] wd [2];
    rsp_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      wd = '{16'h0055, 16'h0066};
      for (int i = 0; i < 2; i++) begin
        req_valid = 1'b1; req_op = (pass == 0); req_addr = 16'h15 + 16'(i);
        req_wdata = wd[i];
        step();
      end
      req_valid = 1'b0;
      t0 = -1; t1 = -1; d0 = 16'h0; d1 = 16'h0;
      for (int k = 0; k < 20; k++) begin
        if (rsp_valid) begin
          if (t0 < 0) begin t0 = k; d0 = rsp_rdata; end
          else if (t1 < 0) begin t1 = k; d1 = rsp_rdata; end
        end
        step();
      end
      total++;
      if (t0 < 0 || t1 - t0 !== 3 + pass) begin
        bad++;
        $display("FAIL thruput_gap_%0d: got gap=%0d required %0d", pass, t1 - t0, 3 + pass);
      end
      if (pass == 1) begin
        total++;
        if (d0 !== 16'h0055 || d1 !== 16'h0066) begin
          bad++;
          $display("FAIL thruput_data: got %h %h required 0055 0066", d0, d1);
        end
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_range();
    int lat; logic op; logic [15:0] rd; logic err; int b0;
    logic [15:0] addrs [2];
    addrs = '{16'h20, 16'h1A};
    for (int i = 0; i < 2; i++) begin
      b0 = bus_cnt;
      send_req(1'b0, addrs[i], 16'h0);
      wait_rsp(lat, op, rd, err);
`ifdef MEM_BUS_CTRL_RANGE_CHECK_EN
      total++;
      if (bus_cnt - b0 !== 0 || err !== 1'b1 || rd !== 16'h0 || lat !== 2) begin
        bad++;
        $display("FAIL range_%h: got strobes=%0d err=%b rd=%h lat=%0d required 0/1/0000/2",
                 addrs[i], bus_cnt - b0, err, rd, lat);
      end
`else
      total++;
      if (bus_cnt - b0 !== 1 || err !== 1'b0 || rd !== 16'h0 || lat !== 4) begin
        bad++;
        $display("FAIL norange_%h: got strobes=%0d err=%b rd=%h lat=%0d required 1/0/0000/4",
                 addrs[i], bus_cnt - b0, err, rd, lat);
      end
`endif
      ack_rsp();
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    bit seen;
    logic [15:0] addrs [3];
    addrs = '{16'h12, 16'h13, 16'h14};
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_op = 1'b0; req_addr = addrs[i];
      step();
    end
    req_valid = 1'b0;
    total++;
    if (fifo_level !== 3'd2) begin
      bad++;
      $display("FAIL mid_queued: got level=%0d required 2", fifo_level);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    b0 = bus_cnt;
    total++;
    if (bus_valid !== 1'b0 || fifo_level !== 3'd0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got bus_v=%b level=%0d rsp_v=%b required 0/0/0",
               bus_valid, fifo_level, rsp_valid);
    end
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) seen = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    total++;
    if (seen !== 1'b0 || bus_cnt - b0 !== 0) begin
      bad++;
      $display("FAIL mid_dropped: got rsp_seen=%b strobes=%0d required 0/0", seen, bus_cnt - b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ffff_and_unwritten();
    test_back_to_back();
    test_throughput();
    test_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
